// File: rtl/sponge_cut_controller_pkg.sv
// Shared sizing and FSM encoding for the sponge-mode circuit-under-test.
package configuration;
   localparam int DATA_WIDTH = 16;
   localparam int RATE       = 8;
   localparam int N          = 16;
   localparam int B          = 88;

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      PERM_WAIT,
      SQUEEZE,
      DONE
   } sponge_state_t;
endpackage

// File: rtl/sponge_block_mux.sv
// Picks the rate block to absorb: a message slice, or the pad block
// once the block index has run past the message.
module sponge_block_mux
   import configuration::*;
#(
   parameter int DATA_WIDTH = configuration::DATA_WIDTH,
   parameter int RATE       = configuration::RATE,
   parameter int BW         = 2
)(
   input  logic [DATA_WIDTH-1:0] i_msg,
   input  logic [BW-1:0]         i_blk,
   output logic [RATE-1:0]       o_blk
);
   localparam int NM = DATA_WIDTH / RATE;
   localparam logic [RATE-1:0] PAD = {1'b1, {(RATE-1){1'b0}}};

   always_comb begin
      o_blk = PAD;
      for (int k = 0; k < NM; k++) begin
         if (i_blk == BW'(k)) o_blk = i_msg[k*RATE +: RATE];
      end
   end
endmodule

// File: rtl/sponge_cut_controller.sv
// Sponge sequencer: absorbs the message plus one pad block through an
// external permutation, then squeezes the digest a rate block at a time.
module sponge_cut_controller
   import configuration::*;
#(
   parameter int DATA_WIDTH = configuration::DATA_WIDTH,
   parameter int RATE       = configuration::RATE,
   parameter int N          = configuration::N,
   parameter int B          = configuration::B,
   parameter logic [B-1:0] IV = '0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] input_to_cut,
   output logic                  perm_start,
   output logic [B-1:0]          perm_state_in,
   input  logic                  perm_done,
   input  logic [B-1:0]          perm_state_out,
   output logic [N-1:0]          output_from_cut,
   output logic                  end_cut
);
   localparam int NM  = DATA_WIDTH / RATE;
   localparam int NB  = NM + 1;
   localparam int NSQ = N / RATE;
   localparam int NP  = NB + NSQ - 1;
   localparam int BW  = $clog2(NP + 1);
   localparam int SQW = (NSQ > 1) ? $clog2(NSQ) : 1;

   sponge_state_t r_state, w_next;

   logic [B-1:0]          r_sv;
   logic [DATA_WIDTH-1:0] r_msg;
   logic [N-1:0]          r_out;
   logic [BW-1:0]         r_blk;
   logic [SQW-1:0]        r_sq;
   logic                  r_sqz;
   logic [RATE-1:0]       w_blk;
   logic [B-1:0]          w_mixed;
   logic                  w_last_blk;
   logic                  w_last_sq;

   sponge_block_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .RATE       (RATE),
      .BW         (BW)
   ) u_mux (
      .i_msg (r_msg),
      .i_blk (r_blk),
      .o_blk (w_blk)
   );

   assign w_mixed    = r_sv ^ {{(B-RATE){1'b0}}, w_blk};
   assign w_last_blk = (r_blk == BW'(NB - 1));
   assign w_last_sq  = (r_sq == SQW'(NSQ - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // perm_state_in is re-derived in PERM_WAIT so it stays stable until done
   always_comb begin
      w_next        = r_state;
      perm_start    = 1'b0;
      perm_state_in = '0;
      unique case (r_state)
         IDLE: w_next = ABSORB;
         ABSORB: begin
            perm_start    = 1'b1;
            perm_state_in = w_mixed;
            w_next        = PERM_WAIT;
         end
         PERM_WAIT: begin
            perm_state_in = r_sqz ? r_sv : w_mixed;
            if (perm_done) begin
               if (r_sqz || w_last_blk) w_next = SQUEEZE;
               else                     w_next = ABSORB;
            end
         end
         SQUEEZE: begin
            if (w_last_sq) begin
               w_next = DONE;
            end else begin
               perm_start    = 1'b1;
               perm_state_in = r_sv;
               w_next        = PERM_WAIT;
            end
         end
         DONE: w_next = DONE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sv  <= IV;
         r_msg <= '0;
         r_out <= '0;
         r_blk <= '0;
         r_sq  <= '0;
         r_sqz <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_msg <= input_to_cut;
               r_blk <= '0;
               r_sq  <= '0;
               r_sqz <= 1'b0;
            end
            PERM_WAIT: begin
               if (perm_done) begin
                  r_sv  <= perm_state_out;
                  r_blk <= r_blk + BW'(1);
                  if (!r_sqz && w_last_blk) begin
                     r_sqz <= 1'b1;
                     r_sq  <= '0;
                  end
               end
            end
            SQUEEZE: begin
               for (int i = 0; i < NSQ; i++) begin
                  if (r_sq == SQW'(i)) r_out[i*RATE +: RATE] <= r_sv[RATE-1:0];
               end
               if (!w_last_sq) r_sq <= r_sq + SQW'(1);
            end
            default: ;
         endcase
      end
   end

   assign output_from_cut = r_out;
   assign end_cut         = (r_state == DONE);
endmodule

// File: tb/tb_sponge_cut_controller.sv
// Random and directed runs against a rotate-left stub permutation and
// a plain-arithmetic sponge reference model.
module tb_sponge_cut_controller;
   localparam int DW   = 16;
   localparam int RATE = 8;
   localparam int N    = 16;
   localparam int B    = 16;
   localparam int NM   = DW / RATE;
   localparam int NB   = NM + 1;
   localparam int NSQ  = N / RATE;
   localparam int NP   = NB + NSQ - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] msg = '0;
   logic          perm_start;
   logic [B-1:0]  perm_state_in;
   logic          perm_done = 1'b0;
   logic [B-1:0]  perm_state_out = '0;
   logic [N-1:0]  dig;
   logic          end_cut;

   int checks = 0;
   int errors = 0;
   int lat    = 3;
   bit spur   = 1'b0;
   int viol   = 0;

   always #5 clk = ~clk;

   sponge_cut_controller #(
      .DATA_WIDTH (DW),
      .RATE       (RATE),
      .N          (N),
      .B          (B),
      .IV         ('0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .input_to_cut    (msg),
      .perm_start      (perm_start),
      .perm_state_in   (perm_state_in),
      .perm_done       (perm_done),
      .perm_state_out  (perm_state_out),
      .output_from_cut (dig),
      .end_cut         (end_cut)
   );

   function automatic logic [B-1:0] rotl(input logic [B-1:0] x);
      return {x[B-2:0], x[B-1]};
   endfunction

   function automatic logic [N-1:0] ref_digest(input logic [DW-1:0] m);
      logic [B-1:0] s = '0;
      logic [N-1:0] d = '0;
      for (int k = 0; k < NM; k++) begin
         s[RATE-1:0] = s[RATE-1:0] ^ m[k*RATE +: RATE];
         s = rotl(s);
      end
      s[RATE-1] = ~s[RATE-1];
      s = rotl(s);
      for (int j = 0; j < NSQ; j++) begin
         d[j*RATE +: RATE] = s[RATE-1:0];
         if (j < NSQ - 1) s = rotl(s);
      end
      return d;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // stub permutation: rotate-left by 1, latency lat, optional noise
   int           cnt = 0;
   logic [B-1:0] held = '0;
   logic [B-1:0] res = '0;
   always @(posedge clk) begin
      perm_done <= 1'b0;
      if (perm_start) begin
         if (cnt != 0) viol <= viol + 1;
         held <= perm_state_in;
         res  <= rotl(perm_state_in);
         if (lat == 1) begin
            perm_done      <= 1'b1;
            perm_state_out <= rotl(perm_state_in);
            cnt            <= 0;
         end else begin
            cnt <= lat - 1;
         end
      end else if (cnt != 0) begin
         if (!rst && perm_state_in !== held) viol <= viol + 1;
         cnt <= cnt - 1;
         if (cnt == 1) begin
            perm_done      <= 1'b1;
            perm_state_out <= res;
         end
      end else if (spur && $urandom_range(0, 2) == 0) begin
         perm_done      <= 1'b1;
         perm_state_out <= B'($urandom);
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_rst_end"}, 32'(end_cut), 0);
      check({tag, "_rst_dig"}, 32'(dig), 0);
      check({tag, "_rst_start"}, 32'(perm_start), 0);
      check({tag, "_rst_pin"}, 32'(perm_state_in), 0);
   endtask

   task automatic start_run(input string tag, input logic [DW-1:0] m,
                            input int l, input bit s);
      rst  = 1'b1;
      msg  = m;
      lat  = l;
      spur = s;
      repeat (2) @(negedge clk);
      check_zero(tag);
      rst = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_edge);
      int e = 0;
      int starts = 0;
      while (e < 200) begin
         @(posedge clk);
         e++;
         #1;
         if (perm_start) starts++;
         if (end_cut) break;
      end
      check({tag, "_edge"}, 32'(e), 32'(exp_edge));
      check({tag, "_starts"}, 32'(starts), 32'(NP));
      check({tag, "_digest"}, 32'(dig), 32'(ref_digest(msg)));
      check({tag, "_proto"}, 32'(viol), 0);
   endtask

   initial begin
      logic [DW-1:0] m;
      logic [N-1:0]  d;
      int            l;
      int            bad;

      start_run("nom", 16'h0001, 3, 1'b0);
      wait_done("nom", 18);
      check("nom_const", 32'(dig), 32'h1008);

      start_run("lat1", 16'h0001, 1, 1'b0);
      wait_done("lat1", 10);
      start_run("lat7", 16'h0001, 7, 1'b0);
      wait_done("lat7", 34);

      start_run("spur", 16'h0001, 3, 1'b1);
      wait_done("spur", 18);
      check("spur_const", 32'(dig), 32'h1008);
      repeat (5) @(negedge clk);
      check("spur_done_dig", 32'(dig), 32'h1008);
      check("spur_done_end", 32'(end_cut), 1);
      spur = 1'b0;

      start_run("mid", 16'h0001, 3, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      msg = 16'hFFFF;
      #1;
      check_zero("mid");
      repeat (3) @(negedge clk);
      check_zero("mid2");
      rst = 1'b0;
      wait_done("mid", 18);

      m = 16'hA5C3;
      start_run("hold", m, 3, 1'b0);
      wait_done("hold", 18);
      d   = ref_digest(m);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         msg = DW'($urandom);
         if (!end_cut || dig !== d) bad++;
      end
      check("hold_stable", 32'(bad), 0);
      check("hold_dig", 32'(dig), 32'(d));

      for (int r = 0; r < 8; r++) begin
         m = DW'($urandom);
         l = $urandom_range(1, 7);
         start_run("rnd", m, l, 1'($urandom_range(0, 1)));
         wait_done("rnd", 2 + NP * (l + 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
